// File: rtl/pipe_pkg.sv
// Shared helpers for the pipe_buffer elastic pipeline register:
// tap slicing and parameter legality.
package pipe_pkg;

  function automatic int tapLsb(input int slot, input int width);
    return slot * width;
  endfunction

  function automatic bit paramsLegal(input int depth, input int width);
    return (depth >= 1) && (width >= 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid flag and payload register with load/clear/hold control.
// Load wins over clear; the payload only changes when an entry is loaded.
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_buffer.sv
// Elastic pipeline buffer: DEPTH slots with valid/ready handshake, per-slot flush,
// optional bubble collapsing on stall, and every slot exposed as a tap.
module pipe_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 3,
  parameter int COLLAPSE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic [DEPTH-1:0]           flush_mask,
  output logic [DEPTH-1:0]           tap_valid,
  output logic [DEPTH*WIDTH-1:0]     tap_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (!paramsLegal(DEPTH, WIDTH)) begin : g_bad_params
    $error("pipe_buffer: DEPTH and WIDTH must both be at least 1");
  end

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] accept;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] enter;
  logic [DEPTH-1:0] clear;
  logic [WIDTH-1:0] slotData [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             adv;

  // Acceptance ripples from the output end backwards; in lockstep mode one global advance drives all slots.
  always_comb begin
    logic downstreamAcc;
    adv           = out_ready | ~valid_q[DEPTH-1];
    accept        = '0;
    move          = '0;
    downstreamAcc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (COLLAPSE != 0) begin
        move[k]   = valid_q[k] & downstreamAcc;
        accept[k] = ~valid_q[k] | move[k];
      end else begin
        move[k]   = valid_q[k] & adv;
        accept[k] = adv;
      end
      downstreamAcc = accept[k];
    end
  end

  assign in_ready = accept[0] & reset;

  // A flushed entry still moves for acceptance purposes but never lands in the next slot.
  always_comb begin
    enter    = '0;
    clear    = '0;
    valid_d  = '0;
    enter[0] = in_valid & in_ready;
    for (int k = 1; k < DEPTH; k++) begin
      enter[k] = move[k-1] & ~flush_mask[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      clear[k]   = ~enter[k] & (move[k] | flush_mask[k]);
      valid_d[k] = enter[k] | (valid_q[k] & ~move[k] & ~flush_mask[k]);
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [WIDTH-1:0] srcData;
    if (g == 0) begin : g_head
      assign srcData = in_data;
    end else begin : g_body
      assign srcData = slotData[g-1];
    end

    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i   (clk),
      .rst_ni  (reset),
      .load_i  (enter[g]),
      .clear_i (clear[g]),
      .data_i  (srcData),
      .valid_o (valid_q[g]),
      .data_o  (slotData[g])
    );

    assign tap_data[tapLsb(g, WIDTH) +: WIDTH] = slotData[g];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = slotData[DEPTH-1];
  assign tap_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_buffer.sv
// Bench for pipe_buffer: a collapsing and a lockstep instance share stimulus and are
// compared against slot-list models plus directed expectations.
module tb_pipe_buffer;

  localparam int W  = 32;
  localparam int D  = 3;
  localparam int OW = $clog2(D + 1);
  localparam int VW = 1 + 1 + W + D + D * W + OW;

  logic           clk = 1'b0;
  logic           resetN;
  logic           inValid;
  logic [W-1:0]   inData;
  logic           outReady;
  logic [D-1:0]   flushMask;

  logic           inReady1, outValid1, inReady0, outValid0;
  logic [W-1:0]   outData1, outData0;
  logic [D-1:0]   tapValid1, tapValid0;
  logic [D*W-1:0] tapData1, tapData0;
  logic [OW-1:0]  occ1, occ0;
  logic [VW-1:0]  act1, act0;

  int checks   = 0;
  int failures = 0;

  bit           mv1 [D];
  bit           mv0 [D];
  logic [W-1:0] md1 [D];
  logic [W-1:0] md0 [D];
  int           dest1 [D];

  always #5 clk = ~clk;

  pipe_buffer #(.WIDTH(W), .DEPTH(D), .COLLAPSE(1)) dut1 (
    .clk(clk), .reset(resetN), .in_valid(inValid), .in_data(inData), .in_ready(inReady1),
    .out_valid(outValid1), .out_data(outData1), .out_ready(outReady), .flush_mask(flushMask),
    .tap_valid(tapValid1), .tap_data(tapData1), .occupancy(occ1)
  );

  pipe_buffer #(.WIDTH(W), .DEPTH(D), .COLLAPSE(0)) dut0 (
    .clk(clk), .reset(resetN), .in_valid(inValid), .in_data(inData), .in_ready(inReady0),
    .out_valid(outValid0), .out_data(outData0), .out_ready(outReady), .flush_mask(flushMask),
    .tap_valid(tapValid0), .tap_data(tapData0), .occupancy(occ0)
  );

  assign act1 = {inReady1, outValid1, outData1, tapValid1, tapData1, occ1};
  assign act0 = {inReady0, outValid0, outData0, tapValid0, tapData0, occ0};

  // Walk entries from the output end: each one advances iff the spot ahead ends up free.
  function automatic bit plan1(input bit oRdy);
    bit taken [D];
    for (int k = 0; k < D; k++) begin
      taken[k] = 1'b0;
      dest1[k] = -2;
    end
    for (int k = D - 1; k >= 0; k--) begin
      if (mv1[k]) begin
        if (k == D - 1) dest1[k] = oRdy ? -1 : k;
        else            dest1[k] = taken[k+1] ? k : k + 1;
        if (dest1[k] >= 0) taken[dest1[k]] = 1'b1;
      end
    end
    return !taken[0];
  endfunction

  function automatic logic [VW-1:0] expVec1(input bit oRdy, input bit rst);
    logic [D-1:0]   tv;
    logic [D*W-1:0] td;
    int             cnt;
    bit             rdy;
    rdy = rst && plan1(oRdy);
    cnt = 0;
    tv  = '0;
    td  = '0;
    for (int k = 0; k < D; k++) begin
      tv[k]         = mv1[k];
      td[k*W +: W]  = md1[k];
      cnt          += int'(mv1[k]);
    end
    return {rdy, mv1[D-1], md1[D-1], tv, td, OW'(cnt)};
  endfunction

  function automatic logic [VW-1:0] expVec0(input bit oRdy, input bit rst);
    logic [D-1:0]   tv;
    logic [D*W-1:0] td;
    int             cnt;
    bit             rdy;
    rdy = rst && (oRdy || !mv0[D-1]);
    cnt = 0;
    tv  = '0;
    td  = '0;
    for (int k = 0; k < D; k++) begin
      tv[k]         = mv0[k];
      td[k*W +: W]  = md0[k];
      cnt          += int'(mv0[k]);
    end
    return {rdy, mv0[D-1], md0[D-1], tv, td, OW'(cnt)};
  endfunction

  task automatic clearModel();
    for (int k = 0; k < D; k++) begin
      mv1[k] = 1'b0; md1[k] = '0;
      mv0[k] = 1'b0; md0[k] = '0;
    end
  endtask

  task automatic modelStep();
    bit           nv [D];
    logic [W-1:0] nd [D];
    bit           acc;
    if (!resetN) begin
      clearModel();
      return;
    end
    acc = plan1(outReady) && inValid;
    for (int k = 0; k < D; k++) begin
      nv[k] = 1'b0; nd[k] = md1[k];
    end
    for (int k = 0; k < D; k++) begin
      if (mv1[k] && dest1[k] >= 0 && !flushMask[k]) begin
        nv[dest1[k]] = 1'b1;
        nd[dest1[k]] = md1[k];
      end
    end
    if (acc) begin
      nv[0] = 1'b1; nd[0] = inData;
    end
    mv1 = nv;
    md1 = nd;
    // Lockstep: the whole column shifts together or freezes together.
    for (int k = 0; k < D; k++) begin
      nv[k] = 1'b0; nd[k] = md0[k];
    end
    if (outReady || !mv0[D-1]) begin
      for (int k = 1; k < D; k++) begin
        if (mv0[k-1] && !flushMask[k-1]) begin
          nv[k] = 1'b1; nd[k] = md0[k-1];
        end
      end
      if (inValid) begin
        nv[0] = 1'b1; nd[0] = inData;
      end
    end else begin
      for (int k = 0; k < D; k++) nv[k] = mv0[k] && !flushMask[k];
    end
    mv0 = nv;
    md0 = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0; flushMask = '0;
    clearModel();
    repeat (2) tick();
    checks++;
    if (inReady1 !== 1'b0 || inReady0 !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_in_ready got=%b/%b exp=0/0", inReady1, inReady0);
    end
    checks++;
    if (act1[VW-2:0] !== '0 || act0[VW-2:0] !== '0) begin
      failures++; $display("[TB] FAIL reset_state got=%h/%h exp=0", act1, act0);
    end
    #2 resetN = 1'b1;
    #1;
    checks++;
    if (inReady1 !== 1'b1 || inReady0 !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_release_ready got=%b/%b exp=1/1", inReady1, inReady0);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    outReady = 1'b1; flushMask = '0;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inData = vals[i];
      tick();
      if (i < 2) begin
        checks++;
        if (outValid1 !== 1'b0 || outValid0 !== 1'b0) begin
          failures++; $display("[TB] FAIL stream_latency edge=%0d got=%b/%b exp=0/0", i + 1, outValid1, outValid0);
        end
      end
    end
    inValid = 1'b0; inData = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outValid1 !== (i < 3) || outValid0 !== (i < 3) || occ1 !== OW'(3 - i) || occ0 !== OW'(3 - i)) begin
        failures++;
        $display("[TB] FAIL stream_valid_occ step=%0d got=%b/%b occ=%0d/%0d exp=%b occ=%0d",
                 i, outValid1, outValid0, occ1, occ0, (i < 3), 3 - i);
      end
      if (i < 3) begin
        checks++;
        if (outData1 !== vals[i] || outData0 !== vals[i]) begin
          failures++; $display("[TB] FAIL stream_data step=%0d got=%h/%h exp=%h", i, outData1, outData0, vals[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_collapse_stall();
    outReady = 1'b0; flushMask = '0;
    inValid = 1'b1;
    inData = 32'hA1; tick();
    inData = 32'hB2; tick();
    inData = 32'hC3; tick();
    inValid = 1'b0;
    #1;
    checks++;
    if (inReady1 !== 1'b0 || inReady0 !== 1'b0) begin
      failures++; $display("[TB] FAIL full_in_ready got=%b/%b exp=0/0", inReady1, inReady0);
    end
    flushMask = 3'b010;
    tick();
    flushMask = '0;
    checks++;
    if (tapValid1 !== 3'b101 || tapValid0 !== 3'b101) begin
      failures++; $display("[TB] FAIL bubble_setup got=%b/%b exp=101", tapValid1, tapValid0);
    end
    inValid = 1'b1; inData = 32'hD4;
    #1;
    checks++;
    if (inReady1 !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_collapse_ready got=%b exp=1", inReady1);
    end
    checks++;
    if (inReady0 !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_lockstep_ready got=%b exp=0", inReady0);
    end
    tick();
    checks++;
    if (tapValid1 !== 3'b111 || tapData1 !== {32'hA1, 32'hC3, 32'hD4} || inReady1 !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_collapse_fill got=%b %h rdy=%b exp=111 a1c3d4 rdy=0", tapValid1, tapData1, inReady1);
    end
    checks++;
    if (tapValid0 !== 3'b101 || tapData0 !== {32'hA1, 32'hB2, 32'hC3}) begin
      failures++; $display("[TB] FAIL stall_lockstep_hold got=%b %h exp=101 a1b2c3", tapValid0, tapData0);
    end
    inValid = 1'b0; outReady = 1'b1;
    repeat (4) tick();
    checks++;
    if (occ1 !== '0 || occ0 !== '0 || outValid1 !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_drain got=%0d/%0d exp=0", occ1, occ0);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0; flushMask = '0; inValid = 1'b1;
    inData = 32'hC; tick();
    inData = 32'hB; tick();
    inData = 32'hA; tick();
    inData = 32'hE; flushMask = 3'b010; outReady = 1'b1;
    #1;
    checks++;
    if (outValid1 !== 1'b1 || outData1 !== 32'hC || occ1 !== 2'd3 || outData0 !== 32'hC) begin
      failures++; $display("[TB] FAIL flush_pre got=%b %h occ=%0d exp=1 c occ=3", outValid1, outData1, occ1);
    end
    tick();
    flushMask = '0; inValid = 1'b0;
    checks++;
    if (occ1 !== 2'd2 || tapValid1 !== 3'b011 || tapData1[W +: W] !== 32'hA || tapData1[0 +: W] !== 32'hE) begin
      failures++; $display("[TB] FAIL flush_after_c1 got=occ%0d %b %h exp=occ2 011", occ1, tapValid1, tapData1);
    end
    checks++;
    if (occ0 !== 2'd2 || tapValid0 !== 3'b011 || tapData0[W +: W] !== 32'hA) begin
      failures++; $display("[TB] FAIL flush_after_c0 got=occ%0d %b %h exp=occ2 011", occ0, tapValid0, tapData0);
    end
    tick();
    checks++;
    if (outValid1 !== 1'b1 || outData1 !== 32'hA || outValid0 !== 1'b1 || outData0 !== 32'hA) begin
      failures++; $display("[TB] FAIL flush_next_out got=%b %h / %b %h exp=1 a", outValid1, outData1, outValid0, outData0);
    end
    tick();
    checks++;
    if (outValid1 !== 1'b1 || outData1 !== 32'hE || outValid0 !== 1'b1 || outData0 !== 32'hE) begin
      failures++; $display("[TB] FAIL flush_b_gone got=%b %h / %b %h exp=1 e", outValid1, outData1, outValid0, outData0);
    end
    tick();
  endtask

  task automatic test_flush_full();
    outReady = 1'b0; flushMask = '0; inValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      inData = W'(i); tick();
    end
    inData = 32'h99; flushMask = '1;
    #1;
    checks++;
    if (inReady1 !== 1'b0 || inReady0 !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_all_ready got=%b/%b exp=0/0", inReady1, inReady0);
    end
    tick();
    flushMask = '0; inValid = 1'b0;
    checks++;
    if (occ1 !== '0 || tapValid1 !== '0 || occ0 !== '0 || tapValid0 !== '0) begin
      failures++; $display("[TB] FAIL flush_all_empty got=%0d %b / %0d %b exp=0", occ1, tapValid1, occ0, tapValid0);
    end
  endtask

  task automatic test_flush_input();
    outReady = 1'b0; flushMask = '0;
    inValid = 1'b1; inData = 32'h77; tick();
    inData = 32'hDD; flushMask = 3'b001;
    #1;
    checks++;
    if (inReady1 !== 1'b1 || inReady0 !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_in_ready got=%b/%b exp=1/1", inReady1, inReady0);
    end
    tick();
    inValid = 1'b0; flushMask = '0;
    checks++;
    if (tapValid1 !== 3'b001 || tapData1[0 +: W] !== 32'hDD || occ1 !== 2'd1 ||
        tapValid0 !== 3'b001 || tapData0[0 +: W] !== 32'hDD || occ0 !== 2'd1) begin
      failures++; $display("[TB] FAIL flush_with_input got=%b %h %0d / %b %h %0d exp=001 dd 1",
                           tapValid1, tapData1[0 +: W], occ1, tapValid0, tapData0[0 +: W], occ0);
    end
    outReady = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    outReady = 1'b1; flushMask = '0; inValid = 1'b1;
    inData = 32'h1234; tick();
    inData = 32'h5678; tick();
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (tapValid1 !== '0 || occ1 !== '0 || outValid1 !== 1'b0 || inReady1 !== 1'b0 ||
        tapValid0 !== '0 || occ0 !== '0 || outValid0 !== 1'b0 || inReady0 !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset got=%b %0d %b %b exp=0 0 0 0", tapValid1, occ1, outValid1, inReady1);
    end
    clearModel();
    #1 resetN = 1'b1;
    inData = 32'h5A; tick();
    inValid = 1'b0; inData = '0;
    tick();
    checks++;
    if (outValid1 !== 1'b0 || outValid0 !== 1'b0) begin
      failures++; $display("[TB] FAIL async_early_out got=%b/%b exp=0/0", outValid1, outValid0);
    end
    tick();
    checks++;
    if (outValid1 !== 1'b1 || outData1 !== 32'h5A || outValid0 !== 1'b1 || outData0 !== 32'h5A) begin
      failures++; $display("[TB] FAIL async_first_out got=%b %h / %b %h exp=1 5a", outValid1, outData1, outValid0, outData0);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp1, exp0;
    for (int n = 0; n < 600; n++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      inData   = $urandom;
      outReady = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < D; k++) flushMask[k] = ($urandom_range(0, 9) == 0);
      #1;
      exp1 = expVec1(outReady, resetN);
      exp0 = expVec0(outReady, resetN);
      checks++;
      if (act1 !== exp1) begin
        failures++; $display("[TB] FAIL random_collapse cycle=%0d got=%h exp=%h", n, act1, exp1);
      end
      checks++;
      if (act0 !== exp0) begin
        failures++; $display("[TB] FAIL random_lockstep cycle=%0d got=%h exp=%h", n, act0, exp0);
      end
      tick();
    end
    inValid = 1'b0; flushMask = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_collapse_stall();
    test_flush();
    test_flush_full();
    test_flush_input();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
